// File: rtl/mux_pipeline_scheduler.sv
// Round-robin scheduler feeding a pipelined mux tree: one grant per clock, with a per-level
// skewed sel bus and a valid/index tag that emerges alongside the mux output.
module mux_pipeline_scheduler #(
   parameter int INPUT_COUNT = 2,
   parameter int MUX_SIZE    = 2,
   parameter int LVL_W       = $clog2(MUX_SIZE),
   parameter int LATENCY     = ($clog2(INPUT_COUNT) + LVL_W - 1) / LVL_W,
   parameter int SEL_W       = LATENCY * LVL_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic                           flush,
   input  logic [INPUT_COUNT-1:0]         req,
   output logic [INPUT_COUNT-1:0]         gnt,
   output logic [SEL_W-1:0]               mux_sel,
   output logic                           out_valid,
   output logic [$clog2(INPUT_COUNT)-1:0] out_index
);

   localparam int IDX_W = $clog2(INPUT_COUNT);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] next_ptr;
   logic [IDX_W:0]   cand;
   logic             found;
   logic             grant;

   // Stage 0 is the issue register; stage LATENCY is what the consumer sees.
   logic [LATENCY:0] valid_pipe;
   logic [IDX_W-1:0] index_pipe [0:LATENCY];

   // Scan offsets from the far end back toward ptr so the nearest requester wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int o = INPUT_COUNT - 1; o >= 0; o--) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(o);
         if (cand >= (IDX_W+1)'(INPUT_COUNT)) begin
            cand = cand - (IDX_W+1)'(INPUT_COUNT);
         end
         if (req[cand[IDX_W-1:0]]) begin
            winner = cand[IDX_W-1:0];
            found  = 1'b1;
         end
      end
   end

   assign next_ptr = (winner == IDX_W'(INPUT_COUNT - 1)) ? '0 : winner + 1'b1;
   assign grant    = en && !flush && found;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         gnt        <= '0;
         valid_pipe <= '0;
         for (int s = 0; s <= LATENCY; s++) begin
            index_pipe[s] <= '0;
         end
      end else begin
         gnt           <= '0;
         valid_pipe[0] <= 1'b0;
         if (grant) begin
            gnt           <= {{(INPUT_COUNT-1){1'b0}}, 1'b1} << winner;
            valid_pipe[0] <= 1'b1;
            index_pipe[0] <= winner;
            ptr           <= next_ptr;
         end
         // Flush kills in-flight tags but lets the index/sel stages keep shifting.
         for (int s = 1; s <= LATENCY; s++) begin
            valid_pipe[s] <= flush ? 1'b0 : valid_pipe[s-1];
            index_pipe[s] <= index_pipe[s-1];
         end
      end
   end

   for (genvar d = 0; d < LATENCY; d++) begin : g_sel
      assign mux_sel[d*LVL_W +: LVL_W] = LVL_W'(index_pipe[d] >> (d * LVL_W));
   end

   assign out_valid = valid_pipe[LATENCY];
   assign out_index = index_pipe[LATENCY];

endmodule

// File: tb/tb_mux_pipeline_scheduler.sv
// Bench for mux_pipeline_scheduler: two configurations (10 inputs radix 2, 16 inputs radix 4)
// checked every cycle against a round-robin reference model and a stand-in downstream mux tree.
module tb_mux_pipeline_scheduler;

   localparam int CN  [2] = '{10, 16};
   localparam int CM  [2] = '{2, 4};
   localparam int CL  [2] = '{4, 2};
   localparam int CLW [2] = '{1, 2};

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        flush;
   logic [9:0]  req_a;
   logic [9:0]  gnt_a;
   logic [3:0]  sel_a;
   logic        ov_a;
   logic [3:0]  oi_a;
   logic [15:0] req_b;
   logic [15:0] gnt_b;
   logic [3:0]  sel_b;
   logic        ov_b;
   logic [3:0]  oi_b;

   int          errors = 0;
   int          checks = 0;
   int          n_edge = 0;

   int          ptr_m  [2];
   int          last_m [2];
   logic [15:0] gnt_m  [2];
   bit          hv     [2][64];
   int          hi     [2][64];
   int          tree   [2][4][16];

   mux_pipeline_scheduler #(.INPUT_COUNT(10), .MUX_SIZE(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .req(req_a),
      .gnt(gnt_a), .mux_sel(sel_a), .out_valid(ov_a), .out_index(oi_a)
   );

   mux_pipeline_scheduler #(.INPUT_COUNT(16), .MUX_SIZE(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .req(req_b),
      .gnt(gnt_b), .mux_sel(sel_b), .out_valid(ov_b), .out_index(oi_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_winner(input logic [15:0] r, input int p, input int n);
      for (int o = 0; o < n; o++) begin
         int k;
         k = (p + o) % n;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   // Reference: grants by first requester at/after ptr; history of issue slots by edge number.
   task automatic model_step(input int c, input logic [15:0] r, input logic [7:0] sel);
      int n, m, l, lw, w, f, nodes, leaf;
      n  = CN[c];
      m  = CM[c];
      l  = CL[c];
      lw = CLW[c];
      for (int d = l - 1; d >= 1; d--) begin
         f = (32'(sel) >> (d * lw)) & ((1 << lw) - 1);
         nodes = 1;
         for (int k = 0; k < l - 1 - d; k++) nodes = nodes * m;
         for (int g = 0; g < nodes; g++) tree[c][d][g] = tree[c][d-1][g*m + f];
      end
      f = 32'(sel) & ((1 << lw) - 1);
      nodes = 1;
      for (int k = 0; k < l - 1; k++) nodes = nodes * m;
      for (int g = 0; g < nodes; g++) begin
         leaf = g * m + f;
         tree[c][0][g] = (leaf < n) ? leaf : 0;
      end
      if (!rst_n) begin
         for (int k = 0; k < 64; k++) begin
            hv[c][k] = 1'b0;
            hi[c][k] = 0;
         end
         ptr_m[c]  = 0;
         last_m[c] = 0;
         gnt_m[c]  = '0;
         return;
      end
      w = (en && !flush) ? rr_winner(r, ptr_m[c], n) : -1;
      if (flush) begin
         for (int j = 1; j <= l; j++) hv[c][(n_edge - j) & 63] = 1'b0;
      end
      if (w >= 0) begin
         gnt_m[c]  = 16'(1) << w;
         hv[c][n_edge & 63] = 1'b1;
         last_m[c] = w;
         ptr_m[c]  = (w + 1) % n;
      end else begin
         gnt_m[c]  = '0;
         hv[c][n_edge & 63] = 1'b0;
      end
      hi[c][n_edge & 63] = last_m[c];
   endtask

   always @(posedge clk) begin
      n_edge++;
      model_step(0, {6'b0, req_a}, {4'b0, sel_a});
      model_step(1, req_b, {4'b0, sel_b});
   end

   task automatic check_output(input int c, input logic [15:0] g, input logic [7:0] sel,
                               input logic ov, input logic [3:0] oi);
      int l, lw, k, mask;
      l    = CL[c];
      lw   = CLW[c];
      mask = (1 << lw) - 1;
      k    = (n_edge - l) & 63;
      check($sformatf("cfg%0d gnt", c), 32'(g), 32'(gnt_m[c]));
      check($sformatf("cfg%0d out_valid", c), 32'(ov), 32'(hv[c][k]));
      if (hv[c][k]) begin
         check($sformatf("cfg%0d out_index", c), 32'(oi), 32'(hi[c][k]));
         check($sformatf("cfg%0d mux_out", c), 32'(tree[c][l-1][0]), 32'(hi[c][k]));
      end
      for (int d = 0; d < l; d++) begin
         check($sformatf("cfg%0d sel_field%0d", c, d), (32'(sel) >> (d * lw)) & mask,
               (hi[c][(n_edge - d) & 63] >> (d * lw)) & mask);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check_output(0, {6'b0, gnt_a}, {4'b0, sel_a}, ov_a, oi_a);
         check_output(1, gnt_b, {4'b0, sel_b}, ov_b, oi_b);
      end
   end

   task automatic apply_stimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " gnt_a"}, 32'(gnt_a), 0);
      check({tag, " sel_a"}, 32'(sel_a), 0);
      check({tag, " ov_a"},  32'(ov_a), 0);
      check({tag, " oi_a"},  32'(oi_a), 0);
      check({tag, " gnt_b"}, 32'(gnt_b), 0);
      check({tag, " sel_b"}, 32'(sel_b), 0);
      check({tag, " ov_b"},  32'(ov_b), 0);
      check({tag, " oi_b"},  32'(oi_b), 0);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      en    = 1'b0;
      flush = 1'b0;
      req_a = '0;
      req_b = '0;
      apply_stimulus();
      apply_stimulus();
      check_all_zero("reset");
      rst_n = 1'b1;
      en    = 1'b1;

      // Single request: grant next cycle, tag and data LATENCY cycles after that.
      req_a = 10'h004;
      apply_stimulus();
      check("single gnt", 32'(gnt_a), 32'h004);
      req_a = '0;
      repeat (3) apply_stimulus();
      check("single early ov", 32'(ov_a), 0);
      apply_stimulus();
      check("single ov", 32'(ov_a), 1);
      check("single oi", 32'(oi_a), 2);
      check("single mux_out", 32'(tree[0][3][0]), 2);
      apply_stimulus();
      check("single ov pulse", 32'(ov_a), 0);

      // Full load starting from ptr=3; 25 grants leave ptr at 8.
      req_a = 10'h3FF;
      apply_stimulus();
      check("rotate gnt0", 32'(gnt_a), 32'h008);
      apply_stimulus();
      check("rotate gnt1", 32'(gnt_a), 32'h010);
      repeat (23) apply_stimulus();

      // Wrap and fairness between inputs 9 and 0.
      req_a = 10'h201;
      apply_stimulus();
      check("wrap gnt9", 32'(gnt_a), 32'h200);
      apply_stimulus();
      check("wrap gnt0", 32'(gnt_a), 32'h001);
      apply_stimulus();
      check("wrap gnt9b", 32'(gnt_a), 32'h200);
      req_a = '0;
      repeat (2) apply_stimulus();

      // Enable low for three cycles; pointer must resume at 3.
      req_a = 10'h3FF;
      repeat (3) apply_stimulus();
      en = 1'b0;
      repeat (3) begin
         apply_stimulus();
         check("en_low gnt", 32'(gnt_a), 0);
      end
      en = 1'b1;
      apply_stimulus();
      check("en_resume gnt", 32'(gnt_a), 32'h008);
      repeat (8) apply_stimulus();

      // Flush after four grants: only the grant after the flush reaches the output.
      req_a = '0;
      repeat (6) apply_stimulus();
      req_a = 10'h3FF;
      repeat (4) apply_stimulus();
      flush = 1'b1;
      apply_stimulus();
      cnt = int'(ov_a);
      flush = 1'b0;
      apply_stimulus();
      cnt += int'(ov_a);
      req_a = '0;
      repeat (8) begin
         apply_stimulus();
         cnt += int'(ov_a);
      end
      check("flush survivors", 32'(cnt), 1);

      // Randomized traffic on both configurations with a mid-cycle asynchronous reset.
      for (int i = 0; i < 500; i++) begin
         req_a = 10'($urandom);
         req_b = 16'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            req_a = req_a & 10'($urandom) & 10'($urandom);
            req_b = req_b & 16'($urandom) & 16'($urandom);
         end
         en    = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 29) == 0);
         apply_stimulus();
         if (i == 250) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_all_zero("async_reset");
            apply_stimulus();
            apply_stimulus();
            rst_n = 1'b1;
         end
      end
      req_a = '0;
      req_b = '0;
      flush = 1'b0;
      repeat (6) apply_stimulus();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
